load_store_unit: RTL
====================

# load_store_unit

Memory-access initiator between the datapath's execute stage and the word-organised data memory. Accepts one load or store request at a time in RISC-V byte-address form (lb, lh, lw, lbu, lhu, sb, sh, sw) and translates it into word-indexed memRead/memWrite transactions. Sub-word stores use read-modify-write. Checks alignment and range, extracts and sign- or zero-extends load data, and stalls the datapath through `busy` until the access completes.

## Interface
Parameters:
- WORD_COUNT, 32: number of 32-bit words in data memory; valid word index is 0..WORD_COUNT-1.

Ports:
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- request  input  1  start an access; sampled on a rising edge while in IDLE
- isStore  input  1  1 = store, 0 = load
- funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- byteAddress  input  32  byte address of the access
- storeData  input  32  store operand; low 8/16/32 bits used
- loadData  output  32  extended load result; held until the next load completes
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- fault  output  1  one-cycle pulse, coincident with done, for a rejected request
- memAddress  output  32  word index = latched byteAddress[31:2]
- memWriteData  output  32  word to write; 0 outside WRITE
- memRead  output  1  high only in READ
- memWrite  output  1  high only in WRITE
- memReadData  input  32  combinational read data from memory while memRead is high

## Operation
- States: IDLE, READ, WRITE, DONE, FAULT.
- IDLE with request=1 at an edge: latch isStore, funct3, byteAddress and storeData, then branch:
  - Fault condition -> FAULT.
  - Load -> READ.
  - sw -> WRITE.
  - sb/sh -> READ.
- Fault conditions, any of:
  - funct3 in {011, 110, 111}.
  - Store with funct3 100 or 101.
  - h/hu with byteAddress[0]=1.
  - w with byteAddress[1:0] != 00.
  - byteAddress[31:2] >= WORD_COUNT.
  - A faulted request issues no memory access.
- READ:
  - Load: capture memReadData at the edge, extract the lane, extend, write loadData, then go to DONE.
  - sb/sh: capture the old word, then go to WRITE.
- WRITE:
  - sw: memWriteData = storeData.
  - sb: old word with byte lane byteAddress[1:0] replaced by storeData[7:0].
  - sh: old word with half lane byteAddress[1] replaced by storeData[15:0].
  - Next state is DONE.
- DONE: done=1 for one cycle, then IDLE. FAULT: done=1 and fault=1 for one cycle, then IDLE.
- Lanes are little-endian:
  - Byte k occupies bits [8k+7:8k].
  - Half h occupies bits [16h+15:16h].
- Extension: b/h sign-extend from bit 7/15; bu/hu zero-extend; w passes through unchanged.
- request is ignored in every state except IDLE. The datapath holds the request inputs stable only for the accepting edge.
- Stores and faults leave loadData unchanged.

## Timing
- Request accepted at edge k. Pulse cycles and memory strobes by access type:
  - Fault: done/fault high in cycle k+1.
  - Load: memRead high in cycle k+1; done high in cycle k+2.
  - sw: memWrite high in cycle k+1; done high in cycle k+2.
  - sb/sh: memRead in cycle k+1, memWrite in cycle k+2, done in cycle k+3.
- memAddress is stable from cycle k+1 until the next accepted request.
- Memory commits the write at the edge ending the WRITE cycle. A load issued immediately after a store completes observes the new data.
- Back-to-back throughput: the next request is accepted at the edge that ends DONE/FAULT, i.e. the earliest edge where busy=0.
- Reset asserted (low), at any time, takes effect immediately:
  - State returns to IDLE.
  - loadData, memAddress and memWriteData go to 0.
  - busy, done, fault, memRead and memWrite go to 0.
  - Reset during READ of sb/sh aborts with no write issued.
  - Reset during WRITE drops memWrite before the edge, so no write is committed if reset precedes that edge.
- Reset release is followed by the first request sample at the next rising edge.

## Test plan
- Reset: drive reset=0 mid-sequence -> all outputs 0 immediately. Release, then hold request=0 -> outputs remain 0 and busy=0.
- Word path: sw 0xDEADBEEF at 0x0C -> memAddress=3, memWrite=1 in cycle k+1, done at k+2. Then lw 0x0C -> memRead in cycle k+1, loadData=0xDEADBEEF with done at k+2.
- Load extension, with word 3 = 0x80F17F01:
  - lb 0x0E -> 0xFFFFFFF1; lbu 0x0E -> 0x000000F1.
  - lh 0x0E -> 0xFFFF80F1; lhu 0x0E -> 0x000080F1.
  - lb 0x0D -> 0x0000007F.
- Sub-word stores, with word 3 = 0x11223344:
  - sb 0x0D, data 0xAA -> READ then WRITE of 0x1122AA44, done at k+3.
  - Then sh 0x0E, data 0xBEEF -> 0xBEEFAA44.
- Faults: each of the following -> done=fault=1 at k+1, with memRead and memWrite never asserted:
  - lw 0x0D.
  - sh 0x0F.
  - lw 0x80 (word 32).
  - funct3=011.
  - Store with funct3=100.
- Busy and reset interplay:
  - request pulsed during READ of an sb -> ignored; exactly one done.
  - Reset asserted during READ of sb 0x0D -> memory word unchanged and no memWrite pulse.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Datapath request/response and data-memory signals of the load/store unit.
// The LSU takes the slave modport; the datapath/memory environment takes master.
interface load_store_unit_if;
    logic        request;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] byteAddress;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;

    modport master (
        output request, isStore, funct3, byteAddress, storeData, memReadData,
        input  loadData, busy, done, fault, memAddress, memWriteData, memRead, memWrite
    );

    modport slave (
        input  request, isStore, funct3, byteAddress, storeData, memReadData,
        output loadData, busy, done, fault, memAddress, memWriteData, memRead, memWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store to word-memory translator; sub-word stores do read-modify-write.
// Latency: fault 1, load/sw 2, sb/sh 3 cycles to done; busy stalls the datapath, requests taken only when idle.
module load_store_unit #(
    parameter int WORD_COUNT = 32
) (
    input  logic             clock,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam logic [31:0] WORD_LIMIT = 32'(WORD_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] store_low_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        req_fault_d;
    logic [7:0]  rd_byte_d;
    logic [15:0] rd_half_d;
    logic [31:0] load_ext_d;
    logic [31:0] merged_d;

    always_comb begin
        req_fault_d = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11)
                   || (bus.isStore && bus.funct3[2])
                   || ((bus.funct3[1:0] == 2'b01) && bus.byteAddress[0])
                   || ((bus.funct3 == 3'b010) && (bus.byteAddress[1:0] != 2'b00))
                   || ({2'b00, bus.byteAddress[31:2]} >= WORD_LIMIT);
    end

    // Little-endian lane pick from the word currently being read.
    always_comb begin
        rd_byte_d = bus.memReadData[{lane_q, 3'b000} +: 8];
        rd_half_d = bus.memReadData[{lane_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext_d = {{24{rd_byte_d[7]}}, rd_byte_d};
            3'b100:  load_ext_d = {24'h000000, rd_byte_d};
            3'b001:  load_ext_d = {{16{rd_half_d[15]}}, rd_half_d};
            3'b101:  load_ext_d = {16'h0000, rd_half_d};
            default: load_ext_d = bus.memReadData;
        endcase
    end

    always_comb begin
        merged_d = bus.memReadData;
        if (funct3_q[0]) begin
            merged_d[{lane_q[1], 4'b0000} +: 16] = store_low_q;
        end else begin
            merged_d[{lane_q, 3'b000} +: 8] = store_low_q[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            is_store_q       <= 1'b0;
            funct3_q         <= 3'b000;
            lane_q           <= 2'b00;
            store_low_q      <= 16'h0000;
            load_data_q      <= 32'h0;
            mem_address_q    <= 32'h0;
            mem_write_data_q <= 32'h0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            fault_q          <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.request) begin
                        is_store_q    <= bus.isStore;
                        funct3_q      <= bus.funct3;
                        lane_q        <= bus.byteAddress[1:0];
                        store_low_q   <= bus.storeData[15:0];
                        mem_address_q <= {2'b00, bus.byteAddress[31:2]};
                        busy_q        <= 1'b1;
                        if (req_fault_d) begin
                            state_q <= S_FAULT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (bus.isStore && (bus.funct3 == 3'b010)) begin
                            state_q          <= S_WRITE;
                            mem_write_q      <= 1'b1;
                            mem_write_data_q <= bus.storeData;
                        end else begin
                            state_q    <= S_READ;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    mem_read_q <= 1'b0;
                    if (is_store_q) begin
                        state_q          <= S_WRITE;
                        mem_write_q      <= 1'b1;
                        mem_write_data_q <= merged_d;
                    end else begin
                        state_q     <= S_DONE;
                        load_data_q <= load_ext_d;
                        done_q      <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q          <= S_DONE;
                    mem_write_q      <= 1'b0;
                    mem_write_data_q <= 32'h0;
                    done_q           <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.loadData     = load_data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.fault        = fault_q;
    assign bus.memAddress   = mem_address_q;
    assign bus.memWriteData = mem_write_data_q;
    assign bus.memRead      = mem_read_q;
    assign bus.memWrite     = mem_write_q;
endmodule
